// File: rtl/dbg_pkg.sv
// Shared definitions for the debug run-control block: FSM state encoding
// and the default widths of the step counter and the core cycle counter.
package dbg_pkg;

  typedef enum logic [1:0] {
    DBGRUN  = 2'b00,
    DBGHALT = 2'b01,
    DBGSTEP = 2'b10
  } dbg_state_t;

  localparam int DBG_STEP_W_DEFAULT = 8;
  localparam int DBG_CYC_W_DEFAULT  = 32;

endpackage

// File: rtl/dbg_clk_gate.sv
// Glitch-free clock gate for the debug core clock. The enable is captured by
// a latch that is transparent only while sys_clk is low, so the AND gate sees
// a stable enable for the whole high phase and never emits a partial pulse.
module dbg_clk_gate
  import dbg_pkg::*;
(
  input  logic sys_clk,
  input  logic clk_en,
  output logic dbg_clk
);

  logic gate;

  // Low-phase transparent latch holding the enable across the high phase
  always_latch begin
    if (!sys_clk) gate = clk_en;
  end

  assign dbg_clk = sys_clk & gate;

endmodule

// File: rtl/dbg_run_controller.sv
// Run-control sequencer for the debug core (sys_clk domain). Turns halt/step/
// resume strobes into a registered core clock enable, runs multi-cycle steps,
// and counts enabled core cycles for JTAG readback.
// Optional feature: define DBG_BREAKPOINT_EN to add the cycle-count breakpoint
// (bp_cycle/bp_arm inputs, sticky bp_hit output).
module dbg_run_controller
  import dbg_pkg::*;
#(
  parameter int STEP_W = DBG_STEP_W_DEFAULT,
  parameter int CYC_W  = DBG_CYC_W_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              resume_req,
  input  logic [STEP_W-1:0] step_count,
`ifdef DBG_BREAKPOINT_EN
  input  logic [CYC_W-1:0]  bp_cycle,
  input  logic              bp_arm,
`endif
  output logic              dbg_clk,
  output logic              clk_en,
  output logic              halted,
  output logic              stepping,
  output logic [CYC_W-1:0]  cycle_cnt
`ifdef DBG_BREAKPOINT_EN
  ,
  output logic              bp_hit
`endif
);

  dbg_state_t        state;
  logic [STEP_W-1:0] step_rem;
  logic [CYC_W-1:0]  cnt_inc;
  logic              bp_fire;

  // A zero step count still runs one cycle; step_rem holds cycles left after the current one
  function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] n);
    return (n == '0) ? '0 : n - STEP_W'(1);
  endfunction

  assign cnt_inc = cycle_cnt + CYC_W'(1);

`ifdef DBG_BREAKPOINT_EN
  // Fire on the edge that would complete the bp_cycle-th enabled cycle
  assign bp_fire = bp_arm && clk_en && (cnt_inc == bp_cycle) &&
                   ((state == DBGRUN) || (state == DBGSTEP));
`else
  assign bp_fire = 1'b0;
`endif

  // Run-control FSM with step down-counter, enabled-cycle counter and registered status
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= DBGRUN;
      clk_en    <= 1'b1;
      step_rem  <= '0;
      cycle_cnt <= '0;
      halted    <= 1'b0;
      stepping  <= 1'b0;
    end else begin
      if (clk_en) cycle_cnt <= cnt_inc;

      case (state)
        DBGRUN: begin
          if (halt_req || bp_fire) begin
            state    <= DBGHALT;
            clk_en   <= 1'b0;
            halted   <= 1'b1;
            stepping <= 1'b0;
          end
        end

        DBGHALT: begin
          if (halt_req) begin
            state <= DBGHALT;
          end else if (step_req) begin
            state    <= DBGSTEP;
            clk_en   <= 1'b1;
            step_rem <= step_load(step_count);
            halted   <= 1'b0;
            stepping <= 1'b1;
          end else if (resume_req) begin
            state    <= DBGRUN;
            clk_en   <= 1'b1;
            halted   <= 1'b0;
            stepping <= 1'b0;
          end
        end

        DBGSTEP: begin
          if (halt_req || bp_fire) begin
            state    <= DBGHALT;
            clk_en   <= 1'b0;
            halted   <= 1'b1;
            stepping <= 1'b0;
          end else if (resume_req) begin
            state    <= DBGRUN;
            halted   <= 1'b0;
            stepping <= 1'b0;
          end else if (step_rem == '0) begin
            state    <= DBGHALT;
            clk_en   <= 1'b0;
            halted   <= 1'b1;
            stepping <= 1'b0;
          end else begin
            step_rem <= step_rem - STEP_W'(1);
          end
        end

        default: begin
          state    <= DBGRUN;
          clk_en   <= 1'b1;
          halted   <= 1'b0;
          stepping <= 1'b0;
        end
      endcase
    end
  end

`ifdef DBG_BREAKPOINT_EN
  // Sticky breakpoint flag, cleared only by reset or an accepted step/resume
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bp_hit <= 1'b0;
    end else if (bp_fire) begin
      bp_hit <= 1'b1;
    end else if ((state == DBGHALT) && !halt_req && (step_req || resume_req)) begin
      bp_hit <= 1'b0;
    end
  end
`endif

  dbg_clk_gate u_clk_gate (
    .sys_clk (sys_clk),
    .clk_en  (clk_en),
    .dbg_clk (dbg_clk)
  );

endmodule
